// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types and constants for the reset sequencer
package rst_seq_pkg;

   localparam int RST_CNT_W = 8;

   typedef enum logic [1:0] {
      CAUSE_POR  = 2'd0,
      CAUSE_SW   = 2'd1,
      CAUSE_EXT  = 2'd2,
      CAUSE_RSVD = 2'd3
   } rst_cause_e;

   typedef enum logic [1:0] {
      ST_ASSERT,
      ST_RELEASE,
      ST_DONE
   } rst_seq_state_e;

endpackage

// File: rtl/rst_seq_sync2.sv
// rtl/rst_seq_sync2.sv - two-flop synchroniser for a single level signal
module rst_seq_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - reset stretcher and staged release sequencer with cause/count reporting
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sw_rst_req_i,
   input  logic                  ext_rst_req_i,
   output logic [NUM_STAGES-1:0] rst_o,
   output logic                  rst_n_o,
   output logic                  done_o,
   output logic [1:0]            rst_cause_o,
   output logic [RST_CNT_W-1:0]  rst_cnt_o
);

   localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int IDX_W   = $clog2(NUM_STAGES + 1);

   localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_STAGES - 1);
   localparam logic [NUM_STAGES-1:0] ALL_ONES  = '1;

   logic ext_req_s;
   logic req;
   logic enter_assert;

   rst_seq_state_e          state_d, state_q;
   logic [CNT_W-1:0]        hold_d, hold_q;
   logic [CNT_W-1:0]        gap_d, gap_q;
   logic [IDX_W-1:0]        idx_d, idx_q;
   logic [NUM_STAGES-1:0]   rst_o_d, rst_o_q;
   logic                    rst_n_d, rst_n_q;
   logic                    done_d, done_q;
   rst_cause_e              cause_d, cause_q;
   logic [RST_CNT_W-1:0]    cnt_d, cnt_q;

   rst_seq_sync2 u_ext_sync (
      .clk (clk),
      .rst (rst),
      .d_i (ext_rst_req_i),
      .q_o (ext_req_s)
   );

   assign req = sw_rst_req_i | ext_req_s;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      gap_d        = gap_q;
      idx_d        = idx_q;
      rst_o_d      = rst_o_q;
      done_d       = done_q;
      cause_d      = cause_q;
      cnt_d        = cnt_q;
      enter_assert = 1'b0;

      if (req) begin
         cause_d = ext_req_s ? CAUSE_EXT : CAUSE_SW;
      end

      case (state_q)
         ST_ASSERT: begin
            rst_o_d = ALL_ONES;
            done_d  = 1'b0;
            if (req) begin
               hold_d = '0;
            end else if (hold_q == HOLD_LAST) begin
               hold_d  = '0;
               gap_d   = '0;
               rst_o_d = ALL_ONES << 1;
               if (NUM_STAGES == 1) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RELEASE;
                  idx_d   = IDX_W'(1);
               end
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            if (req) begin
               enter_assert = 1'b1;
            end else if (gap_q == GAP_LAST) begin
               // Shifting keeps the outputs a thermometer code: stages only release in order.
               gap_d   = '0;
               rst_o_d = rst_o_q << 1;
               idx_d   = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (req) begin
               enter_assert = 1'b1;
            end
         end
         default: begin
            state_d = ST_ASSERT;
         end
      endcase

      if (enter_assert) begin
         state_d = ST_ASSERT;
         rst_o_d = ALL_ONES;
         done_d  = 1'b0;
         hold_d  = '0;
         gap_d   = '0;
         idx_d   = '0;
         if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      rst_n_d = ~rst_o_d[NUM_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ASSERT;
         hold_q  <= '0;
         gap_q   <= '0;
         idx_q   <= '0;
         rst_o_q <= ALL_ONES;
         rst_n_q <= 1'b0;
         done_q  <= 1'b0;
         cause_q <= CAUSE_POR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         rst_o_q <= rst_o_d;
         rst_n_q <= rst_n_d;
         done_q  <= done_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rst_o       = rst_o_q;
   assign rst_n_o     = rst_n_q;
   assign done_o      = done_q;
   assign rst_cause_o = cause_q;
   assign rst_cnt_o   = cnt_q;

endmodule
